// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM state encoding and memory op kind.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_STORE = 1'b1
  } lsu_op_e;

endpackage

// File: rtl/lsu_unit.sv
// Load/store unit: takes one decoded memory op, runs the memory valid/ready
// handshake and writes load results back through the register-file write port.
//
// state | meaning
// IDLE  | ready for a new op; malformed ops are dropped with illegal_op
// REQ   | memory request held until the matching ready is sampled
// WB    | load result presented to the register file, op_done
// DONE  | store complete, op_done
module lsu_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic [DATA_W-1:0]     rs_data,
  input  logic [DATA_W-1:0]     rt_data,
  input  logic [REG_ADDR_W-1:0] rd,
  output logic                  mem_read_valid,
  output logic [ADDR_W-1:0]     mem_read_addr,
  input  logic                  mem_read_ready,
  input  logic [DATA_W-1:0]     mem_read_data,
  output logic                  mem_write_valid,
  output logic [ADDR_W-1:0]     mem_write_addr,
  output logic [DATA_W-1:0]     mem_write_data,
  input  logic                  mem_write_ready,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0]     write_data,
  output logic                  op_done,
  output logic                  illegal_op
);

  lsu_state_e            state_q;
  lsu_op_e               op_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     rdata_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  illegal_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= OP_LOAD;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (issue_valid) begin
            if (is_load ^ is_store) begin
              addr_q  <= rs_data[ADDR_W-1:0];
              wdata_q <= rt_data;
              rd_q    <= rd;
              op_q    <= is_load ? OP_LOAD : OP_STORE;
              state_q <= REQ;
            end else begin
              illegal_q <= 1'b1;
            end
          end
        end
        REQ: begin
          // Only the ready matching the op in flight can advance the FSM.
          if (op_q == OP_LOAD) begin
            if (mem_read_ready) begin
              rdata_q <= mem_read_data;
              state_q <= WB;
            end
          end else if (mem_write_ready) begin
            state_q <= DONE;
          end
        end
        WB:      state_q <= IDLE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign issue_ready     = (state_q == IDLE);
  assign mem_read_valid  = (state_q == REQ) && (op_q == OP_LOAD);
  assign mem_write_valid = (state_q == REQ) && (op_q == OP_STORE);
  assign mem_read_addr   = addr_q;
  assign mem_write_addr  = addr_q;
  assign mem_write_data  = wdata_q;
  assign reg_write       = (state_q == WB);
  assign write_reg       = rd_q;
  assign write_data      = rdata_q;
  assign op_done         = (state_q == WB) || (state_q == DONE);
  assign illegal_op      = illegal_q;

endmodule

// File: tb/tb_lsu_unit.sv
// Directed bench for lsu_unit: hand-computed vectors, outputs sampled on the falling edge.
module tb_lsu_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid, issue_ready, is_load, is_store;
  logic [7:0] rs_data, rt_data;
  logic [3:0] rd;
  logic       mem_read_valid, mem_read_ready;
  logic [7:0] mem_read_addr, mem_read_data;
  logic       mem_write_valid, mem_write_ready;
  logic [7:0] mem_write_addr, mem_write_data;
  logic       reg_write;
  logic [3:0] write_reg;
  logic [7:0] write_data;
  logic       op_done, illegal_op;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_unit dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .is_load(is_load), .is_store(is_store),
    .rs_data(rs_data), .rt_data(rt_data), .rd(rd),
    .mem_read_valid(mem_read_valid), .mem_read_addr(mem_read_addr),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .op_done(op_done), .illegal_op(illegal_op)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Present an op at the falling edge, hold it across one rising edge, then withdraw it.
  task automatic issue(input logic ld, input logic st, input logic [7:0] rs,
                       input logic [7:0] rt, input logic [3:0] rdi);
    @(negedge clk);
    is_load = ld; is_store = st; rs_data = rs; rt_data = rt; rd = rdi;
    issue_valid = 1'b1;
    @(posedge clk);
    #1 issue_valid = 1'b0;
  endtask

  int loads, stores, dones;
  logic drop_next;

  initial begin
    reset = 1'b1;
    issue_valid = 0; is_load = 0; is_store = 0;
    rs_data = 0; rt_data = 0; rd = 0;
    mem_read_ready = 0; mem_read_data = 0; mem_write_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_rvalid", mem_read_valid, 0);
    chk("rst_wvalid", mem_write_valid, 0);
    chk("rst_reg_write", reg_write, 0);
    chk("rst_op_done", op_done, 0);
    chk("rst_illegal", illegal_op, 0);
    chk("rst_addr", mem_read_addr, 0);
    reset = 1'b0;

    // Zero-wait load
    issue(1, 0, 8'h20, 8'h00, 4'd5);
    @(negedge clk);
    chk("ld_rvalid", mem_read_valid, 1);
    chk("ld_raddr", mem_read_addr, 8'h20);
    chk("ld_issue_ready", issue_ready, 0);
    mem_read_ready = 1; mem_read_data = 8'hA7;
    @(negedge clk);
    mem_read_ready = 0; mem_read_data = 8'h00;
    chk("ld_reg_write", reg_write, 1);
    chk("ld_write_reg", write_reg, 5);
    chk("ld_write_data", write_data, 8'hA7);
    chk("ld_op_done", op_done, 1);
    chk("ld_rvalid_drop", mem_read_valid, 0);
    @(negedge clk);
    chk("ld_reg_write_1cyc", reg_write, 0);
    chk("ld_idle", issue_ready, 1);

    // Store with 3 wait cycles; stray read ready during the first wait
    issue(0, 1, 8'hFF, 8'h3C, 4'd9);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_read_ready = (i == 0);
      chk("st_wvalid", mem_write_valid, 1);
      chk("st_waddr", mem_write_addr, 8'hFF);
      chk("st_wdata", mem_write_data, 8'h3C);
      chk("st_reg_write", reg_write, 0);
      mem_write_ready = (i == 3);
    end
    @(negedge clk);
    mem_write_ready = 0; mem_read_ready = 0;
    chk("st_wvalid_drop", mem_write_valid, 0);
    chk("st_op_done", op_done, 1);
    chk("st_reg_write_done", reg_write, 0);
    @(negedge clk);
    chk("st_op_done_1cyc", op_done, 0);
    chk("st_idle", issue_ready, 1);

    // Stray ready while idle
    mem_read_ready = 1; mem_write_ready = 1;
    @(negedge clk);
    chk("stray_rvalid", mem_read_valid, 0);
    chk("stray_wvalid", mem_write_valid, 0);
    chk("stray_ready", issue_ready, 1);
    chk("stray_done", op_done, 0);
    mem_read_ready = 0; mem_write_ready = 0;

    // Illegal: both set, then neither set
    issue(1, 1, 8'h40, 8'h11, 4'd2);
    @(negedge clk);
    chk("ill_both_pulse", illegal_op, 1);
    chk("ill_both_ready", issue_ready, 1);
    chk("ill_both_rvalid", mem_read_valid, 0);
    chk("ill_both_wvalid", mem_write_valid, 0);
    @(negedge clk);
    chk("ill_both_once", illegal_op, 0);
    issue(0, 0, 8'h41, 8'h12, 4'd3);
    @(negedge clk);
    chk("ill_none_pulse", illegal_op, 1);
    chk("ill_none_rvalid", mem_read_valid, 0);
    @(negedge clk);
    chk("ill_none_once", illegal_op, 0);

    // Back-to-back: issue_valid held while the load is in flight
    loads = 0; stores = 0; dones = 0; drop_next = 0;
    @(negedge clk);
    is_load = 1; is_store = 0; rs_data = 8'h10; rt_data = 8'h00; rd = 4'd1;
    issue_valid = 1;
    @(posedge clk);
    @(negedge clk);
    is_load = 0; is_store = 1; rs_data = 8'h11; rt_data = 8'h55; rd = 4'd7;
    for (int i = 0; i < 12; i++) begin
      mem_read_ready  = mem_read_valid;
      mem_write_ready = mem_write_valid;
      mem_read_data   = 8'h99;
      if (reg_write) begin
        loads++;
        chk("b2b_write_reg", write_reg, 1);
        chk("b2b_write_data", write_data, 8'h99);
      end
      if (mem_write_valid) begin
        stores++;
        chk("b2b_waddr", mem_write_addr, 8'h11);
        chk("b2b_wdata", mem_write_data, 8'h55);
      end
      if (op_done) dones++;
      drop_next = issue_ready && issue_valid;
      @(posedge clk);
      #1 if (drop_next) issue_valid = 0;
      @(negedge clk);
    end
    mem_read_ready = 0; mem_write_ready = 0;
    chk("b2b_loads", loads, 1);
    chk("b2b_stores", stores, 1);
    chk("b2b_dones", dones, 2);
    chk("b2b_idle", issue_ready, 1);

    // Reset during REQ of a load
    issue(1, 0, 8'h77, 8'h00, 4'd4);
    @(negedge clk);
    chk("rm_rvalid_before", mem_read_valid, 1);
    #1 reset = 1;
    #1;
    chk("rm_rvalid_async", mem_read_valid, 0);
    chk("rm_issue_ready", issue_ready, 1);
    chk("rm_addr_cleared", mem_read_addr, 0);
    @(negedge clk);
    reset = 0;
    mem_read_ready = 1; mem_read_data = 8'hEE;
    loads = 0;
    repeat (3) begin
      @(negedge clk);
      if (reg_write) loads++;
    end
    mem_read_ready = 0;
    chk("rm_no_reg_write", loads, 0);
    chk("rm_idle", issue_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout got running exp finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
